dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports CLK_in in 1, clock; all state updates on its rising edge.
REQ-002 SHALL have Reset_in in 1; reset is asynchronous and active-high.
REQ-003 SHALL have Run_en in 1; high while the CPU program is running (started, not halted).
REQ-004 SHALL have CpuReq_in in 1, CpuWrite_in in 1, CpuAdd_in in 32 and CpuData_in in 32; these are the CPU request, write select, address and write data.
REQ-005 SHALL have CpuAck_out out 1 and CpuData_out out 32; these are the CPU completion pulse and read data.
REQ-006 SHALL have IoReq_in in 1, IoWrite_in in 1, IoAdd_in in 32 and IoData_in in 32; these are the external IO port request, write select, address and write data.
REQ-007 SHALL have IoAck_out out 1 and IoData_out out 32; these are the IO completion pulse and read data.
REQ-008 SHALL have MemAdd_out out 32, MemData_out out 32, MemRead_en out 1 and MemWrite_en out 1, which drive the single data memory port.
REQ-009 SHALL have MemData_in in 32, the combinational read data from the data memory.
REQ-010 SHALL have Busy_out out 1, high in any state other than IDLE.
REQ-011 SHALL have Owner_out out 1, set to 1 when the IO side holds the current or last grant.

Function
REQ-012 SHALL implement a 4-state FSM with states IDLE, CPU_ACC, IO_ACC and RESP.
REQ-013 SHALL, in IDLE, sample the requests at the edge and move to CPU_ACC or IO_ACC per REQ-015 to REQ-017, and stay in IDLE if no request is eligible.
REQ-014 SHALL, on the grant edge, latch the winner's write select, address and write data; later changes on the requester inputs do not affect the access in flight.
REQ-015 SHALL make a CPU request eligible only when Run_en=1; when Run_en=0, CpuReq_in is ignored and CpuAck_out stays 0.
REQ-016 SHALL give the CPU priority over IO when both are eligible, except as stated in REQ-017.
REQ-017 SHALL keep a 3-bit starvation counter: increment it on each CPU grant while IoReq_in=1, clear it on each IO grant, and force an IO grant when the counter equals 4 and IO is requesting.
REQ-018 SHALL, in CPU_ACC and IO_ACC, drive MemAdd_out and MemData_out from the latched request, and assert exactly one of MemWrite_en (write) or MemRead_en (read) for exactly that one cycle.
REQ-019 SHALL hold both memory enables at 0 in IDLE and RESP; MemAdd_out and MemData_out keep their last latched values there.
REQ-020 SHALL, at the end of an ACC cycle, register MemData_in into the winner's data output on a read; on a write, that data output keeps its previous value.
REQ-021 SHALL, at the end of an ACC cycle, enter RESP and assert the winner's Ack for exactly one cycle (RESP), then return to IDLE unconditionally.
REQ-022 SHALL give a latency of 2 cycles: a request sampled at edge k has its Ack high in cycle k+2 and its data valid from that cycle until the next read grant to the same side.
REQ-023 SHALL require requesters to hold Req until Ack; a Req still high in the RESP cycle is not a new request, and the next grant is sampled only in IDLE.
REQ-024 SHALL drop a request withdrawn before its grant edge with no memory access and no Ack; withdrawal after the grant does not abort the access.
REQ-025 SHALL let an access already granted complete and Ack normally if Run_en falls during CPU_ACC or RESP.
REQ-026 SHALL pass the 32-bit address and data through unmodified; no alignment check and no wrap arithmetic.

Reset
REQ-027 SHALL, while Reset_in=1, immediately and asynchronously force state IDLE and the counter to 0, and force all outputs to 0: both Acks, both data outputs, MemAdd_out, MemData_out, both memory enables, Busy_out and Owner_out.
REQ-028 SHALL abort any in-flight access on reset with no Ack; after release, the first sampled edge evaluates requests afresh.

Verification
REQ-029 SHALL pass the IO write scenario: Run_en=0, IoReq/IoWrite=1, IoAdd=0x10, IoData=0xDEADBEEF -> MemWrite_en=1 with those values for 1 cycle, IoAck_out=1 two cycles after the request edge.
REQ-030 SHALL pass the CPU read scenario: Run_en=1, CPU read of 0x10 with MemData_in=0xDEADBEEF -> MemRead_en=1 for 1 cycle, CpuData_out=0xDEADBEEF, CpuAck_out pulse of 1 cycle.
REQ-031 SHALL pass the priority and starvation scenario: both Req held continuously, Run_en=1 -> grant sequence CPU,CPU,CPU,CPU,IO,CPU..., with one RESP cycle between grants.
REQ-032 SHALL pass the Run_en gating scenario: CpuReq_in=1, Run_en=0 for 10 cycles -> no CpuAck_out and no memory strobes; Run_en raised -> Ack 2 cycles later.
REQ-033 SHALL pass the mid-access reset scenario: Reset_in asserted during IO_ACC -> MemWrite_en drops the same cycle (asynchronously), no IoAck_out, Busy_out=0.
REQ-034 SHALL pass the withdrawal scenario: IoReq_in pulsed 1 cycle while a CPU access is in progress -> no IO access and no IoAck_out.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU and the external IO port.
// Each grant runs IDLE -> ACC -> RESP -> IDLE, giving a two-cycle request-to-ack latency.
module dmem_arbiter (
    input  logic        CLK_in,
    input  logic        Reset_in,
    input  logic        Run_en,
    input  logic        CpuReq_in,
    input  logic        CpuWrite_in,
    input  logic [31:0] CpuAdd_in,
    input  logic [31:0] CpuData_in,
    output logic        CpuAck_out,
    output logic [31:0] CpuData_out,
    input  logic        IoReq_in,
    input  logic        IoWrite_in,
    input  logic [31:0] IoAdd_in,
    input  logic [31:0] IoData_in,
    output logic        IoAck_out,
    output logic [31:0] IoData_out,
    output logic [31:0] MemAdd_out,
    output logic [31:0] MemData_out,
    output logic        MemRead_en,
    output logic        MemWrite_en,
    input  logic [31:0] MemData_in,
    output logic        Busy_out,
    output logic        Owner_out
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, IO_ACC, RESP} state_t;

    state_t     stateReg;
    logic [2:0] starveCnt;
    logic       cpuEligible;
    logic       grantIo;

    assign cpuEligible = CpuReq_in & Run_en;
    // IO wins when the CPU is not eligible, or when it has been passed over four times.
    assign grantIo     = IoReq_in & (~cpuEligible | (starveCnt == 3'd4));

    always_ff @(posedge CLK_in or posedge Reset_in) begin
        if (Reset_in) begin
            stateReg    <= IDLE;
            starveCnt   <= 3'd0;
            CpuAck_out  <= 1'b0;
            IoAck_out   <= 1'b0;
            CpuData_out <= 32'd0;
            IoData_out  <= 32'd0;
            MemAdd_out  <= 32'd0;
            MemData_out <= 32'd0;
            MemRead_en  <= 1'b0;
            MemWrite_en <= 1'b0;
            Busy_out    <= 1'b0;
            Owner_out   <= 1'b0;
        end else begin
            CpuAck_out  <= 1'b0;
            IoAck_out   <= 1'b0;
            MemRead_en  <= 1'b0;
            MemWrite_en <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (grantIo) begin
                        stateReg    <= IO_ACC;
                        MemAdd_out  <= IoAdd_in;
                        MemData_out <= IoData_in;
                        MemWrite_en <= IoWrite_in;
                        MemRead_en  <= ~IoWrite_in;
                        Busy_out    <= 1'b1;
                        Owner_out   <= 1'b1;
                        starveCnt   <= 3'd0;
                    end else if (cpuEligible) begin
                        stateReg    <= CPU_ACC;
                        MemAdd_out  <= CpuAdd_in;
                        MemData_out <= CpuData_in;
                        MemWrite_en <= CpuWrite_in;
                        MemRead_en  <= ~CpuWrite_in;
                        Busy_out    <= 1'b1;
                        Owner_out   <= 1'b0;
                        if (IoReq_in)
                            starveCnt <= starveCnt + 3'd1;
                    end
                end
                // The strobe registers still hold the latched write select during ACC.
                CPU_ACC: begin
                    stateReg   <= RESP;
                    CpuAck_out <= 1'b1;
                    if (!MemWrite_en)
                        CpuData_out <= MemData_in;
                end
                IO_ACC: begin
                    stateReg  <= RESP;
                    IoAck_out <= 1'b1;
                    if (!MemWrite_en)
                        IoData_out <= MemData_in;
                end
                RESP: begin
                    stateReg <= IDLE;
                    Busy_out <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    Busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
